// File: rtl/arcade_input_cond.sv
// Input conditioning ahead of the in0/in1 packing: merge, rotate, debounce and coin shaping.
// Optional autofire on the fire button is built when ARCADE_INPUT_COND_AUTOFIRE_EN is defined.
module arcade_input_cond #(
  parameter int unsigned DEB_CYCLES      = 4096,
  parameter int unsigned COIN_FRAMES     = 4,
  parameter int unsigned LOCK_FRAMES     = 8,
  parameter int unsigned AUTOFIRE_FRAMES = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       rotate,
  input  logic       vblank,
  input  logic [7:0] kbjoy,
  input  logic [7:0] joystick_0,
  input  logic [7:0] joystick_1,
  output logic       m_up,
  output logic       m_down,
  output logic       m_left,
  output logic       m_right,
  output logic       m_fire,
  output logic       m_start1,
  output logic       m_start2,
  output logic       m_coin,
  output logic       coin_busy
);

  typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT} coinState_e;

  localparam logic [15:0] DEB_LIM  = 16'(DEB_CYCLES);
  localparam logic [7:0]  COIN_LIM = 8'(COIN_FRAMES);
  localparam logic [7:0]  LOCK_LIM = 8'(LOCK_FRAMES);

  // Control bit order: 0 up, 1 down, 2 left, 3 right, 4 fire, 5 start1, 6 start2, 7 coin
  logic [7:0]  joy;
  logic [7:0]  merged_d, merged_q;
  logic [7:0]  deb_d, deb_q;
  logic [15:0] debCnt_d [8];
  logic [15:0] debCnt_q [8];
  logic        vblankDly_q;
  logic        tick;
  logic        coinPrev_q;
  logic        coinRise;
  coinState_e  coinState_d, coinState_q;
  logic [7:0]  coinCnt_d, coinCnt_q;
  logic        unusedJoy;

  assign joy       = joystick_0 | joystick_1;
  assign unusedJoy = ^joy[7:5];
  assign tick      = vblank & ~vblankDly_q;
  assign coinRise  = deb_q[7] & ~coinPrev_q;

  always_comb begin
    merged_d    = 8'd0;
    merged_d[4] = kbjoy[0] | joy[4];
    merged_d[5] = kbjoy[1];
    merged_d[6] = kbjoy[2];
    merged_d[7] = kbjoy[3];
    if (rotate) begin
      merged_d[0] = kbjoy[6] | joy[1];
      merged_d[1] = kbjoy[7] | joy[0];
      merged_d[2] = kbjoy[5] | joy[2];
      merged_d[3] = kbjoy[4] | joy[3];
    end else begin
      merged_d[0] = kbjoy[4] | joy[3];
      merged_d[1] = kbjoy[5] | joy[2];
      merged_d[2] = kbjoy[6] | joy[1];
      merged_d[3] = kbjoy[7] | joy[0];
    end
  end

  // The counter only runs while merged and debounced disagree; any agreeing sample restarts it.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      debCnt_d[i] = 16'd0;
      if (merged_q[i] != deb_q[i]) begin
        if (debCnt_q[i] + 16'd1 == DEB_LIM) begin
          deb_d[i] = merged_q[i];
        end else begin
          debCnt_d[i] = debCnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      merged_q    <= 8'd0;
      deb_q       <= 8'd0;
      vblankDly_q <= 1'b0;
      coinPrev_q  <= 1'b0;
      for (int i = 0; i < 8; i++) debCnt_q[i] <= 16'd0;
    end else begin
      merged_q    <= merged_d;
      deb_q       <= deb_d;
      vblankDly_q <= vblank;
      coinPrev_q  <= deb_q[7];
      for (int i = 0; i < 8; i++) debCnt_q[i] <= debCnt_d[i];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coinState_q <= IDLE;
      coinCnt_q   <= 8'd0;
    end else begin
      coinState_q <= coinState_d;
      coinCnt_q   <= coinCnt_d;
    end
  end

  // Coin edges seen outside IDLE are dropped, so a press never queues a second credit.
  always_comb begin
    coinState_d = coinState_q;
    coinCnt_d   = coinCnt_q;
    case (coinState_q)
      IDLE: begin
        if (coinRise) begin
          coinState_d = PULSE;
          coinCnt_d   = 8'd0;
        end
      end
      PULSE: begin
        if (tick) begin
          if (coinCnt_q + 8'd1 == COIN_LIM) begin
            coinState_d = LOCKOUT;
            coinCnt_d   = 8'd0;
          end else begin
            coinCnt_d = coinCnt_q + 8'd1;
          end
        end
      end
      LOCKOUT: begin
        if (coinCnt_q == LOCK_LIM) begin
          if (!deb_q[7]) coinState_d = IDLE;
        end else if (tick) begin
          coinCnt_d = coinCnt_q + 8'd1;
        end
      end
      default: coinState_d = IDLE;
    endcase
  end

  always_comb begin
    m_coin    = (coinState_q == PULSE);
    coin_busy = (coinState_q != IDLE);
  end

  assign m_up     = deb_q[0];
  assign m_down   = deb_q[1];
  assign m_left   = deb_q[2];
  assign m_right  = deb_q[3];
  assign m_start1 = deb_q[5];
  assign m_start2 = deb_q[6];

`ifdef ARCADE_INPUT_COND_AUTOFIRE_EN
  localparam logic [7:0] AF_LIM = 8'(AUTOFIRE_FRAMES);

  logic       firePhase_d, firePhase_q;
  logic       firePrev_q;
  logic [7:0] afCnt_d, afCnt_q;

  // Release and the first held cycle both re-arm the phase so each press starts firing.
  always_comb begin
    firePhase_d = firePhase_q;
    afCnt_d     = afCnt_q;
    if (!deb_q[4] || !firePrev_q) begin
      firePhase_d = 1'b1;
      afCnt_d     = 8'd0;
    end else if (tick) begin
      if (afCnt_q + 8'd1 == AF_LIM) begin
        firePhase_d = ~firePhase_q;
        afCnt_d     = 8'd0;
      end else begin
        afCnt_d = afCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      firePhase_q <= 1'b1;
      firePrev_q  <= 1'b0;
      afCnt_q     <= 8'd0;
    end else begin
      firePhase_q <= firePhase_d;
      firePrev_q  <= deb_q[4];
      afCnt_q     <= afCnt_d;
    end
  end

  assign m_fire = deb_q[4] & firePhase_q;
`else
  logic [7:0] unusedAf;
  assign unusedAf = 8'(AUTOFIRE_FRAMES);
  assign m_fire   = deb_q[4];
`endif

endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Input-conditioning stage directly upstream of the game core's `in0_reg`/`in1_reg` packing.
- Merges PS/2-keyboard joystick bits with both MiST joysticks and applies screen-rotation remapping.
- Debounces each logical control.
- Shapes the coin input into a fixed-length, frame-timed pulse with a lockout, so that one physical press is exactly one credit.
- All outputs are active-high; the top level inverts them when packing.

Parameters:
- DEB_CYCLES, 4096: consecutive clk_sys samples a merged control must differ from its debounced value before the debounced value flips; legal range 1..65535.
- COIN_FRAMES, 4: frame ticks m_coin is held high per credit; legal range 1..255.
- LOCK_FRAMES, 8: frame ticks of lockout after the coin pulse; legal range 0..255.
- AUTOFIRE_FRAMES, 3: frame ticks per autofire phase; only used with AUTOFIRE_EN; legal range 1..255.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rotate  in  1  1 = rotated control mapping (status[2]).
- vblank  in  1  vertical blank from the game core, clk_sys domain.
- kbjoy  in  8  keyboard bits: [0] fire, [1] start1, [2] start2, [3] coin, [4] up, [5] down, [6] left, [7] right.
- joystick_0  in  8  MiST joystick: [0] right, [1] left, [2] down, [3] up, [4] fire.
- joystick_1  in  8  same layout as joystick_0.
- m_up, m_down, m_left, m_right  out  1  debounced directions.
- m_fire  out  1  debounced fire (autofire-gated if enabled).
- m_start1, m_start2  out  1  debounced starts.
- m_coin  out  1  shaped coin pulse.
- coin_busy  out  1  high while the coin FSM is not IDLE.

Behaviour:
- Reset: every output 0; debounced states 0; all counters 0; coin FSM in IDLE; vblank_d 0.
  - Reset is honoured mid-operation. It aborts a coin pulse or lockout immediately; m_coin is 0 on the cycle after reset is sampled.
- Merge stage, registered with 1-cycle latency. J = joystick_0 | joystick_1.
  - rotate=0: up = kb[4]|J[3]; down = kb[5]|J[2]; left = kb[6]|J[1]; right = kb[7]|J[0].
  - rotate=1: up = kb[6]|J[1]; down = kb[7]|J[0]; left = kb[5]|J[2]; right = kb[4]|J[3].
  - fire = kb[0]|J[4]; start1 = kb[1]; start2 = kb[2]; coin = kb[3].
  - Opposing directions pass through unfiltered; there is no SOCD cleaning.
  - A change of rotate is treated like any input change and goes through debounce.
- Debounce: one instance per merged control (8 total), each with a 16-bit counter.
  - If merged == debounced, the counter clears to 0.
  - Otherwise the counter increments. On the edge where the counter would reach DEB_CYCLES, the debounced value flips and the counter clears.
  - Latency from a raw input edge to the debounced edge is exactly DEB_CYCLES+1 clocks.
  - A glitch shorter than DEB_CYCLES samples never propagates.
- Frame tick: `tick = vblank & ~vblank_d`, one clk_sys cycle wide, once per frame.
- Directions and starts drive their outputs directly from the debounced values.
- Coin FSM, 8-bit frame counter:
  - IDLE: a rising edge of debounced coin moves to PULSE and clears the counter. m_coin=1 from the next cycle.
  - PULSE: the counter increments on each tick. When the count reaches COIN_FRAMES, move to LOCKOUT, clear the counter, m_coin=0.
  - LOCKOUT: the counter increments on each tick, saturating at LOCK_FRAMES. Return to IDLE once count == LOCK_FRAMES and debounced coin == 0; a held coin keeps the FSM in LOCKOUT.
  - Coin edges outside IDLE are ignored, so no credit is queued.
  - A tick in the same cycle as the PULSE entry edge is not counted.
  - coin_busy = (state != IDLE), registered together with the state.
  - A coin held through reset release debounces high DEB_CYCLES+1 cycles later and produces one credit.

Optional Feature:
- Macro: ARCADE_INPUT_COND_AUTOFIRE_EN.
- Defined:
  - A phase bit and 8-bit counter; m_fire = debounced fire & phase.
  - The debounced fire rising edge sets phase=1 and clears the counter.
  - While fire is held, each tick increments the counter. At AUTOFIRE_FRAMES the phase toggles and the counter clears.
  - Release sets phase=1 and clears the counter.
- Undefined: m_fire = debounced fire. The phase logic and AUTOFIRE_FRAMES are unused and no extra registers are built.

Test Plan:
- DEB_CYCLES=4, kbjoy[4] high 3 clocks then low -> m_up stays 0. The same input held 10 clocks -> m_up rises exactly 5 clocks after the input edge.
- rotate=1, joystick_1=8'h02 (left) held -> m_up=1; m_left, m_right and m_down stay 0.
- DEB_CYCLES=4, COIN_FRAMES=4, LOCK_FRAMES=8, 20-clock vblank period, kbjoy[3] held 300 clocks:
  - m_coin high for exactly 4 ticks, then low.
  - coin_busy stays 1 until release is debounced.
  - Only one credit is produced.
- Second coin press during LOCKOUT (tick 2 of 8) -> no second m_coin pulse. A press after coin_busy falls -> a new 4-tick pulse.
- Reset asserted during PULSE -> next cycle m_coin=0, coin_busy=0, all outputs 0. Coin held through reset -> exactly one credit after release.
- With ARCADE_INPUT_COND_AUTOFIRE_EN and AUTOFIRE_FRAMES=3, fire held for 12 ticks -> m_fire pattern 1 for 3 ticks, 0 for 3, 1 for 3, 0 for 3. Without the macro -> m_fire constant 1.
